// File: rtl/cnna_axi_pkg.sv
// Shared AXI constants for the cnna DDR movers: FSM states, beat/4 KB geometry, RRESP codes.
package cnna_axi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int AXI_4K_BYTES = 4096;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    function automatic int beat_bytes(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/axird_burst_gen.sv
// AR channel generator: splits the remaining beats into bursts that stay inside one 4 KB page
// and holds araddr/arlen/arvalid steady until the slave accepts them.
module axird_burst_gen
    import cnna_axi_pkg::*;
#(
    parameter int C_ADDR_WIDTH = 32,
    parameter int C_DATA_WIDTH = 128,
    parameter int C_LEN_WIDTH  = 16,
    parameter int C_MAX_BURST  = 16
) (
    input  logic                    I_clk,
    input  logic                    I_rst_n,
    input  logic                    I_load,
    input  logic                    I_run,
    input  logic                    I_outs_ok,
    input  logic [C_ADDR_WIDTH-1:0] I_base_addr,
    input  logic [C_LEN_WIDTH-1:0]  I_len,
    output logic [C_ADDR_WIDTH-1:0] O_araddr,
    output logic [7:0]              O_arlen,
    output logic                    O_arvalid,
    input  logic                    I_arready
);

    localparam int BPB      = beat_bytes(C_DATA_WIDTH);
    localparam int BPB_LOG2 = $clog2(BPB);
    localparam int BW       = ((C_LEN_WIDTH > 13) ? C_LEN_WIDTH : 13) + 1;

    logic [C_ADDR_WIDTH-1:0] r_addr;
    logic [C_LEN_WIDTH-1:0]  r_rem;
    logic [C_ADDR_WIDTH-1:0] r_araddr;
    logic [7:0]              r_arlen;
    logic                    r_arvalid;

    logic [C_ADDR_WIDTH-1:0] w_cur_addr;
    logic [C_LEN_WIDTH-1:0]  w_cur_rem;
    logic [12:0]             w_4k_bytes;
    logic [BW-1:0]           w_b4k;
    logic [BW-1:0]           w_blen;
    logic                    w_issue;

    // On the start cycle the burst is sized straight from the inputs so arvalid rises next cycle.
    assign w_cur_addr = I_load ? (I_base_addr & ~(C_ADDR_WIDTH'(BPB - 1))) : r_addr;
    assign w_cur_rem  = I_load ? I_len : r_rem;
    assign w_4k_bytes = 13'(AXI_4K_BYTES) - {1'b0, w_cur_addr[11:0]};
    assign w_b4k      = BW'(w_4k_bytes >> BPB_LOG2);

    always_comb begin
        w_blen = BW'(C_MAX_BURST);
        if (w_b4k < w_blen)
            w_blen = w_b4k;
        if (BW'(w_cur_rem) < w_blen)
            w_blen = BW'(w_cur_rem);
    end

    // A new burst may replace the current one in the same edge it is accepted.
    assign w_issue = (I_load | I_run) & (w_cur_rem != '0) & I_outs_ok & (~r_arvalid | I_arready);

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_addr    <= '0;
            r_rem     <= '0;
            r_araddr  <= '0;
            r_arlen   <= '0;
            r_arvalid <= 1'b0;
        end else if (w_issue) begin
            r_araddr  <= w_cur_addr;
            r_arlen   <= 8'(w_blen - BW'(1));
            r_arvalid <= 1'b1;
            r_addr    <= w_cur_addr + (C_ADDR_WIDTH'(w_blen) << BPB_LOG2);
            r_rem     <= w_cur_rem - C_LEN_WIDTH'(w_blen);
        end else if (I_arready || !I_run) begin
            r_arvalid <= 1'b0;
        end
    end

    assign O_araddr  = r_araddr;
    assign O_arlen   = r_arlen;
    assign O_arvalid = r_arvalid;

endmodule

// File: rtl/axird2ram_mburst.sv
// AXI4 multi-burst reader from DDR into an on-chip buffer RAM, ap_start/ap_done controlled.
// Optional AXIRD_RRESP_CHK_EN adds I_maxi_rresp/O_err and drops writes of error beats.
module axird2ram_mburst
    import cnna_axi_pkg::*;
#(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 128,
    parameter int C_RAM_ADDR_WIDTH   = 12,
    parameter int C_LEN_WIDTH        = 16,
    parameter int C_MAX_BURST        = 16,
    parameter int C_MAX_OUTS         = 4
) (
    input  logic                          I_clk,
    input  logic                          I_rst_n,
    input  logic                          I_ap_start,
    output logic                          O_ap_idle,
    output logic                          O_ap_done,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] I_base_addr,
    input  logic [C_LEN_WIDTH-1:0]        I_len,
    input  logic [C_RAM_ADDR_WIDTH-1:0]   I_ram_base,
    output logic [C_RAM_ADDR_WIDTH-1:0]   O_waddr,
    output logic [C_M_AXI_DATA_WIDTH-1:0] O_wdata,
    output logic                          O_wr,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] O_maxi_araddr,
    output logic [7:0]                    O_maxi_arlen,
    output logic                          O_maxi_arvalid,
    input  logic                          I_maxi_arready,
    input  logic                          I_maxi_rvalid,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] I_maxi_rdata,
    input  logic                          I_maxi_rlast,
`ifdef AXIRD_RRESP_CHK_EN
    input  logic [1:0]                    I_maxi_rresp,
    output logic                          O_err,
`endif
    output logic                          O_maxi_rready
);

    localparam int OW = $clog2(C_MAX_OUTS + 1) + 1;

    state_t                        r_state, w_state_nxt;
    logic [C_LEN_WIDTH-1:0]        r_len;
    logic [C_RAM_ADDR_WIDTH-1:0]   r_ram_base;
    logic [C_LEN_WIDTH-1:0]        r_beat;
    logic [OW-1:0]                 r_outs, w_outs_nxt;
    logic                          r_final;
    logic                          r_wr;
    logic [C_RAM_ADDR_WIDTH-1:0]   r_waddr;
    logic [C_M_AXI_DATA_WIDTH-1:0] r_wdata;

    logic w_start, w_load, w_run, w_arvalid, w_ar_hs, w_r_hs, w_rlast_hs, w_last_beat, w_resp_ok;

    assign w_start     = (r_state == ST_IDLE) & I_ap_start;
    assign w_load      = w_start & (I_len != '0);
    assign w_run       = (r_state == ST_RUN);
    assign w_ar_hs     = w_arvalid & I_maxi_arready;
    assign w_r_hs      = I_maxi_rvalid & w_run;
    assign w_rlast_hs  = w_r_hs & I_maxi_rlast;
    // Completion comes from the beat count only; rlast just retires outstanding bursts.
    assign w_last_beat = w_r_hs & (r_beat == r_len - C_LEN_WIDTH'(1));

    always_comb begin
        w_outs_nxt = r_outs;
        case ({w_ar_hs, w_rlast_hs})
            2'b10:   w_outs_nxt = r_outs + OW'(1);
            2'b01:   w_outs_nxt = r_outs - OW'(1);
            default: w_outs_nxt = r_outs;
        endcase
    end

    axird_burst_gen #(
        .C_ADDR_WIDTH (C_M_AXI_ADDR_WIDTH),
        .C_DATA_WIDTH (C_M_AXI_DATA_WIDTH),
        .C_LEN_WIDTH  (C_LEN_WIDTH),
        .C_MAX_BURST  (C_MAX_BURST)
    ) u_burst_gen (
        .I_clk       (I_clk),
        .I_rst_n     (I_rst_n),
        .I_load      (w_load),
        .I_run       (w_run),
        .I_outs_ok   (w_outs_nxt < OW'(C_MAX_OUTS)),
        .I_base_addr (I_base_addr),
        .I_len       (I_len),
        .O_araddr    (O_maxi_araddr),
        .O_arlen     (O_maxi_arlen),
        .O_arvalid   (w_arvalid),
        .I_arready   (I_maxi_arready)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_start) w_state_nxt = (I_len != '0) ? ST_RUN : ST_DONE;
            ST_RUN:  if (r_final) w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

`ifdef AXIRD_RRESP_CHK_EN
    logic r_err;
    assign w_resp_ok = (I_maxi_rresp == AXI_RESP_OKAY);
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n)
            r_err <= 1'b0;
        else if (w_start)
            r_err <= 1'b0;
        else if (w_r_hs && !w_resp_ok)
            r_err <= 1'b1;
    end
    assign O_err = r_err;
`else
    assign w_resp_ok = 1'b1;
`endif

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_state    <= ST_IDLE;
            r_len      <= '0;
            r_ram_base <= '0;
            r_beat     <= '0;
            r_outs     <= '0;
            r_final    <= 1'b0;
            r_wr       <= 1'b0;
            r_waddr    <= '0;
            r_wdata    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_outs  <= w_outs_nxt;
            r_final <= w_last_beat;
            r_wr    <= w_r_hs & w_resp_ok;
            if (w_load) begin
                r_len      <= I_len;
                r_ram_base <= I_ram_base;
                r_beat     <= '0;
            end else if (w_r_hs) begin
                r_beat <= r_beat + C_LEN_WIDTH'(1);
            end
            // Address wraps naturally at the RAM width.
            if (w_r_hs) begin
                r_waddr <= r_ram_base + C_RAM_ADDR_WIDTH'(r_beat);
                r_wdata <= I_maxi_rdata;
            end
        end
    end

    assign O_ap_idle      = (r_state == ST_IDLE);
    assign O_ap_done      = (r_state == ST_DONE);
    assign O_maxi_rready  = w_run;
    assign O_maxi_arvalid = w_arvalid;
    assign O_wr           = r_wr;
    assign O_waddr        = r_waddr;
    assign O_wdata        = r_wdata;

endmodule

// File: tb/tb_axird2ram_mburst.sv
// Directed bench for axird2ram_mburst: small AXI read slave, write/AR loggers, hand-computed checks.
module tb_axird2ram_mburst;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [31:0]  base = '0;
    logic [15:0]  len = '0;
    logic [11:0]  ram_base = '0;
    logic         o_idle, o_done, o_wr, o_arvalid, o_rready;
    logic [11:0]  o_waddr;
    logic [127:0] o_wdata;
    logic [31:0]  o_araddr;
    logic [7:0]   o_arlen;
    logic         arready = 1'b0, rvalid = 1'b0, rlast = 1'b0;
    logic [127:0] rdata = '0;
    logic [1:0]   rresp = 2'b00;
    logic         o_err;

    axird2ram_mburst #(
        .C_M_AXI_ADDR_WIDTH(32), .C_M_AXI_DATA_WIDTH(128), .C_RAM_ADDR_WIDTH(12),
        .C_LEN_WIDTH(16), .C_MAX_BURST(16), .C_MAX_OUTS(2)
    ) dut (
        .I_clk(clk), .I_rst_n(rst_n), .I_ap_start(start), .O_ap_idle(o_idle), .O_ap_done(o_done),
        .I_base_addr(base), .I_len(len), .I_ram_base(ram_base),
        .O_waddr(o_waddr), .O_wdata(o_wdata), .O_wr(o_wr),
        .O_maxi_araddr(o_araddr), .O_maxi_arlen(o_arlen), .O_maxi_arvalid(o_arvalid),
        .I_maxi_arready(arready), .I_maxi_rvalid(rvalid), .I_maxi_rdata(rdata),
        .I_maxi_rlast(rlast),
`ifdef AXIRD_RRESP_CHK_EN
        .I_maxi_rresp(rresp), .O_err(o_err),
`endif
        .O_maxi_rready(o_rready)
    );

`ifndef AXIRD_RRESP_CHK_EN
    assign o_err = 1'b0;
`endif

    always #5 clk = ~clk;

    // stimulus controls (written by the initial block only)
    logic clr = 1'b0, ar_hold = 1'b0, r_hold = 1'b0;
    int   err_beat = -1;
    int   start_cyc = 0;

    // slave / monitor state (written by the negedge block only)
    int          cyc = 0;
    int          q[$];
    int          bcnt = 0, gbeat = 0;
    int          n_ar = 0, n_wr = 0, n_done = 0;
    int          first_rlast = -1, last_rhs = -1, done_cyc = -1, first_arv = -1, idle_cyc = -1;
    int          any_arv = 0, stab_err = 0, wait_cnt = 0;
    logic        prev_wait = 1'b0;
    logic [31:0] pa = '0;
    logic [7:0]  pl = '0;
    logic [31:0] aa [8];
    logic [7:0]  al [8];
    int          ac [8];
    logic [11:0] wa [64];
    logic [31:0] wd [64];

    int n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Everything decided here takes effect at the next posedge; DUT outputs are stable now.
    always @(negedge clk) begin
        cyc++;
        if (clr) begin
            n_ar = 0; n_wr = 0; n_done = 0; gbeat = 0; any_arv = 0; stab_err = 0; wait_cnt = 0;
            first_rlast = -1; last_rhs = -1; done_cyc = -1; first_arv = -1; idle_cyc = -1;
        end
        if (!rst_n) begin
            q.delete(); bcnt = 0; rvalid = 0; rlast = 0; arready = 0; prev_wait = 0;
        end else begin
            if (o_wr) begin
                if (n_wr < 64) begin wa[n_wr] = o_waddr; wd[n_wr] = o_wdata[31:0]; end
                n_wr++;
            end
            if (o_done) begin n_done++; done_cyc = cyc; end
            if (o_idle && done_cyc >= 0 && idle_cyc < 0) idle_cyc = cyc;
            if (o_arvalid) begin any_arv = 1; if (first_arv < 0) first_arv = cyc; end
            if (prev_wait && (!o_arvalid || o_araddr != pa || o_arlen != pl)) stab_err++;
            if (!r_hold && q.size() > 0) begin
                rvalid = 1;
                rdata  = 128'(32'hA000_0000 + 32'(gbeat));
                rlast  = (bcnt == q[0] - 1);
                rresp  = (err_beat >= 0 && gbeat == err_beat) ? 2'b10 : 2'b00;
                if (o_rready) begin
                    last_rhs = cyc; gbeat++; bcnt++;
                    if (rlast) begin
                        void'(q.pop_front()); bcnt = 0;
                        if (first_rlast < 0) first_rlast = cyc;
                    end
                end
            end else begin
                rvalid = 0; rlast = 0; rresp = 2'b00;
            end
            arready = !ar_hold;
            if (o_arvalid && arready) begin
                if (n_ar < 8) begin aa[n_ar] = o_araddr; al[n_ar] = o_arlen; ac[n_ar] = cyc; end
                n_ar++;
                q.push_back(int'(o_arlen) + 1);
            end
            prev_wait = o_arvalid && !arready;
            pa = o_araddr; pl = o_arlen;
            if (prev_wait) wait_cnt++;
        end
    end

    task automatic step();
        @(posedge clk); #2;
    endtask

    task automatic xfer_start(input logic [31:0] a, input logic [15:0] l, input logic [11:0] rb);
        clr = 1; step(); clr = 0;
        base = a; len = l; ram_base = rb; start = 1;
        start_cyc = cyc + 1;
        step(); start = 0;
    endtask

    task automatic wait_done(input string tag);
        int k;
        for (k = 0; k < 400; k++) begin
            if (n_done > 0) break;
            step();
        end
        if (k == 400) chk({tag, "_timeout"}, 0, 1);
        repeat (3) step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) step();
        chk("rst_idle", o_idle, 1);
        chk("rst_done", o_done, 0);
        chk("rst_arvalid", o_arvalid, 0);
        chk("rst_wr", o_wr, 0);
        chk("rst_rready", o_rready, 0);
        rst_n = 1; step();

        // single beat
        xfer_start(32'h1000, 1, 5); wait_done("len1");
        chk("len1_nar", n_ar, 1);
        chk("len1_araddr", aa[0], 32'h1000);
        chk("len1_arlen", al[0], 0);
        chk("len1_arv_lat", first_arv, start_cyc + 1);
        chk("len1_nwr", n_wr, 1);
        chk("len1_waddr", wa[0], 5);
        chk("len1_wdata", wd[0], 32'hA000_0000);
        chk("len1_done_lat", done_cyc, last_rhs + 2);
        chk("len1_idle_lat", idle_cyc, done_cyc + 1);
        chk("len1_ndone", n_done, 1);

        // three bursts
        xfer_start(32'h0, 40, 0); wait_done("len40");
        chk("len40_nar", n_ar, 3);
        chk("len40_a0", {aa[0], 24'h0, al[0]}, {32'h000, 32'd15});
        chk("len40_a1", {aa[1], 24'h0, al[1]}, {32'h100, 32'd15});
        chk("len40_a2", {aa[2], 24'h0, al[2]}, {32'h200, 32'd7});
        chk("len40_nwr", n_wr, 40);
        for (int i = 0; i < 40; i++) begin
            chk($sformatf("len40_waddr%0d", i), wa[i], 64'(i));
            chk($sformatf("len40_wdata%0d", i), wd[i], 64'(32'hA000_0000 + i));
        end
        chk("len40_ndone", n_done, 1);

        // 4 KB crossing
        xfer_start(32'h0FC0, 16, 0); wait_done("x4k");
        chk("x4k_nar", n_ar, 2);
        chk("x4k_a0", {aa[0], 24'h0, al[0]}, {32'h0FC0, 32'd3});
        chk("x4k_a1", {aa[1], 24'h0, al[1]}, {32'h1000, 32'd11});
        chk("x4k_nwr", n_wr, 16);

        // arready held low
        ar_hold = 1;
        xfer_start(32'h2000, 40, 0);
        repeat (12) step();
        ar_hold = 0;
        wait_done("arhold");
        chk("arhold_wait10", wait_cnt >= 10, 1);
        chk("arhold_stable", stab_err, 0);
        chk("arhold_a0", {aa[0], 24'h0, al[0]}, {32'h2000, 32'd15});
        chk("arhold_nwr", n_wr, 40);

        // outstanding limit of 2
        r_hold = 1;
        xfer_start(32'h0, 48, 0);
        repeat (20) step();
        chk("outs_nar_held", n_ar, 2);
        r_hold = 0;
        wait_done("outs");
        chk("outs_nar", n_ar, 3);
        chk("outs_third_ar", ac[2], first_rlast + 1);
        chk("outs_nwr", n_wr, 48);

        // zero length
        xfer_start(32'h100, 0, 3); wait_done("len0");
        chk("len0_nar", n_ar, 0);
        chk("len0_arv", any_arv, 0);
        chk("len0_nwr", n_wr, 0);
        chk("len0_done_lat", done_cyc, start_cyc + 1);

        // RAM address wrap
        xfer_start(32'h5000, 4, 12'd4094); wait_done("wrap");
        chk("wrap_nwr", n_wr, 4);
        chk("wrap_w0", wa[0], 4094);
        chk("wrap_w1", wa[1], 4095);
        chk("wrap_w2", wa[2], 0);
        chk("wrap_w3", wa[3], 1);

        // start held high restarts from IDLE
        clr = 1; step(); clr = 0;
        base = 32'h6000; len = 2; ram_base = 0; start = 1;
        for (int k = 0; k < 200 && n_done < 2; k++) step();
        start = 0;
        repeat (4) step();
        chk("hold_ndone", n_done, 2);
        chk("hold_nar", n_ar, 2);
        chk("hold_nwr", n_wr, 4);

`ifdef AXIRD_RRESP_CHK_EN
        err_beat = 2;
        xfer_start(32'h3000, 8, 10); wait_done("rresp");
        err_beat = -1;
        chk("rresp_nwr", n_wr, 7);
        chk("rresp_w1", wa[1], 11);
        chk("rresp_w2", wa[2], 13);
        chk("rresp_err", o_err, 1);
        xfer_start(32'h3000, 1, 0);
        chk("rresp_err_clr", o_err, 0);
        wait_done("rresp2");
`endif

        // asynchronous reset mid-transfer
        xfer_start(32'h0, 40, 0);
        repeat (4) step();
        rst_n = 0; #1;
        chk("arst_arvalid", o_arvalid, 0);
        chk("arst_rready", o_rready, 0);
        chk("arst_wr", o_wr, 0);
        chk("arst_idle", o_idle, 1);
        chk("arst_done", o_done, 0);
        chk("arst_err", o_err, 0);
        repeat (2) step();
        rst_n = 1;
        repeat (2) step();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/axird2ram_mburst.md
# axird2ram_mburst

Parametrised AXI4 read master that moves a contiguous block of `I_len` beats from DDR into an on-chip buffer RAM (ibuf/wbuf) over the internal RAM write bus. It splits the transfer into multiple bursts, never crossing a 4 KB boundary, and keeps up to `C_MAX_OUTS` read bursts in flight. It sits between the `cnna` AXI master port and the buffer RAMs, and is started and finished by the `ap_start`/`ap_done` handshake from the main control.

## Interface
- `C_M_AXI_ADDR_WIDTH`, 32: AXI byte address width.
- `C_M_AXI_DATA_WIDTH`, 128: AXI and RAM data width; must be a power of two, at least 32.
- `C_RAM_ADDR_WIDTH`, 12: RAM word address width.
- `C_LEN_WIDTH`, 16: width of the total beat count.
- `C_MAX_BURST`, 16: maximum beats per burst; power of two, at most 256.
- `C_MAX_OUTS`, 4: maximum outstanding AR bursts; at least 1.

Ports:
- `I_clk`  in  1  clock; the block has one clock.
- `I_rst_n`  in  1  reset; asynchronous, active-low.
- `I_ap_start`  in  1  level start, sampled only in IDLE.
- `O_ap_idle`  out  1  high in IDLE.
- `O_ap_done`  out  1  one-cycle completion pulse.
- `I_base_addr`  in  C_M_AXI_ADDR_WIDTH  DDR byte address; low log2(bytes/beat) bits are ignored.
- `I_len`  in  C_LEN_WIDTH  total beats.
- `I_ram_base`  in  C_RAM_ADDR_WIDTH  first RAM word address.
- `O_waddr`  out  C_RAM_ADDR_WIDTH; `O_wdata`  out  C_M_AXI_DATA_WIDTH; `O_wr`  out  1: RAM write bus.
- `O_maxi_araddr`  out  C_M_AXI_ADDR_WIDTH; `O_maxi_arlen`  out  8; `O_maxi_arvalid`  out  1; `I_maxi_arready`  in  1: AR channel.
- `I_maxi_rvalid`  in  1; `I_maxi_rdata`  in  C_M_AXI_DATA_WIDTH; `I_maxi_rlast`  in  1; `O_maxi_rready`  out  1: R channel.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN when `I_ap_start`=1 and `I_len`≠0. `I_base_addr`, `I_len` and `I_ram_base` are latched on this transition.
  - IDLE → DONE when `I_ap_start`=1 and `I_len`=0. No AR is issued.
  - RUN → DONE once the final write has been issued.
  - DONE → IDLE unconditionally.
- Burst length is min(`C_MAX_BURST`, beats not yet requested, beats remaining to the next 4 KB boundary). `O_maxi_arlen` = length−1. The next address is the current address plus length×(`C_M_AXI_DATA_WIDTH`/8).
- AR issue in RUN requires: beats still to request > 0, and outstanding < `C_MAX_OUTS`.
- Outstanding counter:
  - +1 on AR handshake.
  - −1 on an R handshake with `I_maxi_rlast`.
  - Both in the same cycle: unchanged.
- `O_maxi_rready`=1 throughout RUN. The RAM never back-pressures. `O_maxi_rready`=0 in IDLE and DONE.
- Each R handshake writes one word.
  - `O_waddr` = latched `I_ram_base` + beat index, wrapping modulo 2^`C_RAM_ADDR_WIDTH`.
  - `O_wdata` = `I_maxi_rdata`.
- The beat counter is `C_LEN_WIDTH` bits. The block ignores `I_maxi_rlast` for completion; completion is decided by the beat count alone.

## Timing
- Reset value of every output is 0, except `O_ap_idle`=1. The FSM resets to IDLE and all counters clear.
- Reset mid-transfer aborts immediately. The interconnect is reset in the same domain, so stray beats are not handled.
- Start sampled at cycle t → `O_maxi_arvalid` asserted at t+1 (registered).
- Once `O_maxi_arvalid` is high, `O_maxi_araddr` and `O_maxi_arlen` stay stable until `I_maxi_arready`. A new address may be presented in the cycle after the handshake.
- R handshake at cycle t → `O_wr`, `O_waddr` and `O_wdata` valid at t+1, one cycle wide.
- Final R handshake at t → final `O_wr` at t+1, `O_ap_done` at t+2, `O_ap_idle` at t+3.
- `len`=0: start at t → `O_ap_done` at t+1.
- `I_ap_start` held high after DONE starts a new transfer from IDLE.

## Configuration
- `AXIRD_RRESP_CHK_EN` defined:
  - Adds port `I_maxi_rresp`  in  2 and output `O_err`  out  1.
  - A beat with `I_maxi_rresp`≠0 is counted but its `O_wr` is suppressed, and `O_err` is set.
  - `O_err` is sticky. It clears on the IDLE→RUN or IDLE→DONE transition.
- Undefined: neither port exists, and every beat is written.

## Structure
- Shared package `cnna_axi_pkg` holds:
  - FSM state localparams.
  - Bytes-per-beat and 4 KB-boundary constants.
  - AXI RRESP codes.
- Sub-module `axird_burst_gen` holds the address/length generator and the AR valid/hold logic. The top holds the FSM, outstanding counter, beat counter and RAM write stage.

## Test plan
- `len`=1, base 0x1000, `ram_base`=5 → one AR (araddr 0x1000, arlen 0); one write at waddr 5; `O_ap_done` two cycles after the rvalid beat.
- `len`=40, base 0x0, `C_MAX_BURST`=16 → ARs (0x000, 15), (0x100, 15), (0x200, 7); 40 writes at addresses 0..39; exactly one done pulse.
- 4 KB crossing: base 0x0FC0, `len`=16 → ARs (0x0FC0, 3) then (0x1000, 11).
- `arready` low for 10 cycles → arvalid, araddr and arlen stable throughout. `C_MAX_OUTS`=2 with rvalid held off → third AR withheld until the first rlast handshake.
- `len`=0 → no arvalid, no wr; done at t+1. `ram_base`=4094 with `len`=4 → waddr 4094, 4095, 0, 1.
- With `AXIRD_RRESP_CHK_EN`: rresp=2 on beat 3 of 8 → 7 writes, waddr `ram_base`+2 skipped, `O_err`=1 until next start. Reset asserted mid-burst → all outputs 0 asynchronously, `O_ap_idle`=1.
